// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module   : debounce_pkg
// Purpose  : Shared state encoding and board default for the debouncer.
// Revision : 1.0
// ============================================================================
package debounce_pkg;

  // 10 ms qualification window at the 50 MHz board clock
  localparam int c_default_debounce_cycles = 500000;

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_RISE_WAIT = 2'd1,
    S_HIGH      = 2'd2,
    S_FALL_WAIT = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_ff
// Purpose  : Multi-stage synchronizer for a single asynchronous input.
// Revision : 1.0
// ============================================================================
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/debounce.sv
`default_nettype none
// ============================================================================
// Module   : debounce
// Purpose  : Synchronize a bouncing button level and release it only after
//            it has held steady for DEBOUNCE_CYCLES clocks.
// Revision : 1.0
// ============================================================================
module debounce
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = c_default_debounce_cycles,
  parameter int SYNC_STAGES     = 2,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic d_raw,
  output logic db,
  output logic busy
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             w_sync;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (d_raw),
    .q     (w_sync)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_LOW;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      S_LOW: begin
        if (w_sync) w_state_nxt = S_RISE_WAIT;
      end
      S_RISE_WAIT: begin
        if (!w_sync)              w_state_nxt = S_LOW;
        else if (r_cnt == c_last) w_state_nxt = S_HIGH;
        else                      w_cnt_nxt   = r_cnt + 1'b1;
      end
      S_HIGH: begin
        if (!w_sync) w_state_nxt = S_FALL_WAIT;
      end
      S_FALL_WAIT: begin
        if (w_sync)               w_state_nxt = S_HIGH;
        else if (r_cnt == c_last) w_state_nxt = S_LOW;
        else                      w_cnt_nxt   = r_cnt + 1'b1;
      end
      default: w_state_nxt = S_LOW;
    endcase
  end

  // Outputs depend on the state register alone, never on the live input
  assign db   = (r_state == S_HIGH) || (r_state == S_FALL_WAIT);
  assign busy = (r_state == S_RISE_WAIT) || (r_state == S_FALL_WAIT);

endmodule
`default_nettype wire
